// File: rtl/regfile_block_transfer.sv
// regfile_block_transfer: LDM/STM-style sequencer moving a register list to/from consecutive memory words.
module regfile_block_transfer #(
    parameter int ADDR_STEP = 4,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [15:0]       reg_list,
    input  logic [31:0]       base_addr,
    output logic [3:0]        rf_rn,
    input  logic [DATA_W-1:0] rf_rd,
    output logic [3:0]        rf_wn,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_we,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [4:0]        count
);
    typedef enum logic [2:0] {IDLE, SCAN, REQ, WB, DONE} state_t;
    state_t      state;
    logic [15:0] list;
    logic [31:0] addr;
    logic        mode_q;
    logic [3:0]  low;
    logic [15:0] rest;
    always_comb begin
        low = '0;
        for (int i = 15; i >= 0; i--)
            if (list[i]) low = 4'(i);
    end
    // rf_rn holds the register being transferred for the whole SCAN..WB span
    assign rest      = list & ~(16'd1 << rf_rn);
    assign mem_wdata = (mem_req && mem_we) ? rf_rd : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            list     <= '0;
            addr     <= '0;
            mode_q   <= 1'b0;
            rf_rn    <= '0;
            rf_wn    <= '0;
            rf_wd    <= '0;
            rf_we    <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
        end else begin
            done  <= 1'b0;
            rf_we <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    list   <= reg_list;
                    mode_q <= mode;
                    addr   <= base_addr;
                    count  <= '0;
                    busy   <= 1'b1;
                    state  <= reg_list == '0 ? DONE : SCAN;
                end
                SCAN: begin
                    rf_rn    <= low;
                    rf_wn    <= low;
                    mem_req  <= 1'b1;
                    mem_we   <= ~mode_q;
                    mem_addr <= addr;
                    state    <= REQ;
                end
                REQ: if (mem_ack) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (mode_q) begin
                        rf_wd <= mem_rdata;
                        rf_we <= 1'b1;
                        state <= WB;
                    end else begin
                        list  <= rest;
                        addr  <= addr + 32'(ADDR_STEP);
                        count <= count + 5'd1;
                        state <= rest == '0 ? DONE : SCAN;
                    end
                end
                WB: begin
                    list  <= rest;
                    addr  <= addr + 32'(ADDR_STEP);
                    count <= count + 5'd1;
                    state <= rest == '0 ? DONE : SCAN;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
